// File: rtl/regfile_write_arbiter.sv
// Register-file write port arbiter: pipeline writeback has priority, LLU results queue in a FIFO,
// and a starvation counter stalls the pipeline to drain them. Define REGFILE_ARB_BYPASS_EN for LLU bypass.
module regfile_write_arbiter #(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           flush,
  input  logic                           wbValid,
  input  logic [4:0]                     wbAddr,
  input  logic [31:0]                    wbData,
  input  logic                           lluValid,
  output logic                           lluReady,
  input  logic [4:0]                     lluAddr,
  input  logic [31:0]                    lluData,
  output logic                           pipeStall,
  output logic                           destinationEnable,
  output logic [4:0]                     writeAddress,
  output logic [31:0]                    writeData,
  output logic                           debugState,
  output logic [$clog2(FIFO_DEPTH):0]    debugCount
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [SW-1:0] LIMIT_C  = SW'(STARVE_LIMIT);
  localparam logic [SW-1:0] LIMIT_M1 = SW'(STARVE_LIMIT - 1);

  typedef enum logic {
    NORMAL = 1'b0,
    STALL  = 1'b1
  } state_t;

  state_t        state;
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic [SW-1:0] starve;
  logic [36:0]   mem [FIFO_DEPTH];
  logic [36:0]   head_entry;

  logic wb_grant;
  logic fifo_grant;
  logic byp_grant;
  logic push;
  logic pop;
  logic starve_inc;

  // LLU handshake: a transfer happens on a rising edge where lluValid && lluReady are both high;
  // while lluReady is low the LLU must hold lluAddr/lluData stable and keep lluValid asserted.
  always_comb begin
    wb_grant   = 1'b0;
    fifo_grant = 1'b0;
    byp_grant  = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    starve_inc = 1'b0;
    count_next = count;
    lluReady   = (count < DEPTH_C) && !flush;
    head_entry = mem[head];

    wb_grant   = (state == NORMAL) && wbValid && (wbAddr != 5'd0);
    fifo_grant = (count != '0) && !wb_grant;
`ifdef REGFILE_ARB_BYPASS_EN
    byp_grant  = (state == NORMAL) && (count == '0) && !wb_grant && lluValid &&
                 (lluAddr != 5'd0) && !flush;
`else
    byp_grant  = 1'b0;
`endif
    pop        = fifo_grant;
    push       = lluValid && lluReady && (lluAddr != 5'd0) && !byp_grant;
    starve_inc = (count != '0) && (state == NORMAL) && wb_grant;

    unique case ({push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state             <= NORMAL;
      head              <= '0;
      tail              <= '0;
      count             <= '0;
      starve            <= '0;
      destinationEnable <= 1'b0;
      writeAddress      <= 5'd0;
      writeData         <= 32'd0;
    end else begin
      // The granted write completes even in a flush cycle.
      if (wb_grant) begin
        destinationEnable <= 1'b1;
        writeAddress      <= wbAddr;
        writeData         <= wbData;
      end else if (fifo_grant) begin
        destinationEnable <= 1'b1;
        writeAddress      <= head_entry[36:32];
        writeData         <= head_entry[31:0];
      end else if (byp_grant) begin
        destinationEnable <= 1'b1;
        writeAddress      <= lluAddr;
        writeData         <= lluData;
      end else begin
        destinationEnable <= 1'b0;
      end

      if (flush) begin
        state  <= NORMAL;
        head   <= '0;
        tail   <= '0;
        count  <= '0;
        starve <= '0;
      end else begin
        if (push) tail <= tail + 1'b1;
        if (pop)  head <= head + 1'b1;
        count <= count_next;

        if (fifo_grant || (count == '0))
          starve <= '0;
        else if (starve_inc && (starve != LIMIT_C))
          starve <= starve + 1'b1;

        unique case (state)
          NORMAL: if (starve_inc && (starve == LIMIT_M1)) state <= STALL;
          STALL:  if (pop && (count_next == '0)) state <= NORMAL;
          default: state <= NORMAL;
        endcase
      end
    end
  end

  // Payload storage needs no reset; count/pointers define which entries are live.
  always_ff @(posedge clock) begin
    if (reset && push) mem[tail] <= {lluAddr, lluData};
  end

  assign pipeStall  = (state == STALL);
  assign debugState = state;
  assign debugCount = count;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with hand-computed expectations and an order scoreboard.
module tb_regfile_write_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        flush;
  logic        wbValid;
  logic [4:0]  wbAddr;
  logic [31:0] wbData;
  logic        lluValid;
  logic        lluReady;
  logic [4:0]  lluAddr;
  logic [31:0] lluData;
  logic        pipeStall;
  logic        destinationEnable;
  logic [4:0]  writeAddress;
  logic [31:0] writeData;
  logic        debugState;
  logic [1:0]  debugCount;

  int vec_count = 0;
  int err_count = 0;
  logic mon_on = 1'b0;
  logic [36:0] exp_q[$];

  regfile_write_arbiter #(.FIFO_DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .wbValid(wbValid), .wbAddr(wbAddr), .wbData(wbData),
    .lluValid(lluValid), .lluReady(lluReady), .lluAddr(lluAddr), .lluData(lluData),
    .pipeStall(pipeStall), .destinationEnable(destinationEnable),
    .writeAddress(writeAddress), .writeData(writeData),
    .debugState(debugState), .debugCount(debugCount)
  );

  // clock/reset block
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_count++;
    if (obs !== exp) begin
      err_count++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_wb(input logic v, input logic [4:0] a, input logic [31:0] d);
    wbValid = v;
    wbAddr  = a;
    wbData  = d;
  endtask

  task automatic drive_llu(input logic v, input logic [4:0] a, input logic [31:0] d);
    lluValid = v;
    lluAddr  = a;
    lluData  = d;
  endtask

  task automatic check_write(input string tag, input logic [4:0] a, input logic [31:0] d);
    check({tag, "_en"}, destinationEnable, 1'b1);
    check({tag, "_addr"}, writeAddress, a);
    check({tag, "_data"}, writeData, d);
  endtask

  task automatic check_sb_write(input string tag);
    logic [36:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 1'b1, 1'b0);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_en"}, destinationEnable, 1'b1);
      check({tag, "_entry"}, {writeAddress, writeData}, e);
    end
  endtask

  // x0 must never be written
  always @(negedge clock) begin
    if (mon_on) check("x0_write", (destinationEnable && (writeAddress == 5'd0)), 1'b0);
  end

  initial begin
    reset = 1'b0;
    flush = 1'b0;
    drive_wb(1'b1, 5'd5, 32'h1234_5678);
    drive_llu(1'b0, 5'd0, 32'd0);

    // reset with wbValid high
    tick();
    tick();
    check("rst_en", destinationEnable, 1'b0);
    check("rst_addr", writeAddress, 5'd0);
    check("rst_data", writeData, 32'd0);
    check("rst_stall", pipeStall, 1'b0);
    check("rst_ready", lluReady, 1'b1);
    check("rst_count", debugCount, 2'd0);

    reset = 1'b1;
    mon_on = 1'b1;
    drive_wb(1'b1, 5'd5, 32'hDEAD_BEEF);
    tick();
    check_write("wb1", 5'd5, 32'hDEAD_BEEF);
    drive_wb(1'b0, 5'd0, 32'd0);
    tick();
    check("idle_en", destinationEnable, 1'b0);
    check("idle_addr_hold", writeAddress, 5'd5);
    check("idle_data_hold", writeData, 32'hDEAD_BEEF);

    // single LLU result into an idle arbiter
    drive_llu(1'b1, 5'd7, 32'h11);
    check("llu1_ready", lluReady, 1'b1);
    tick();
    drive_llu(1'b0, 5'd0, 32'd0);
`ifdef REGFILE_ARB_BYPASS_EN
    check_write("llu1_byp", 5'd7, 32'h11);
    check("llu1_count", debugCount, 2'd0);
    tick();
    check("llu1_after_en", destinationEnable, 1'b0);
`else
    check("llu1_t1_en", destinationEnable, 1'b0);
    check("llu1_count", debugCount, 2'd1);
    tick();
    check_write("llu1_t2", 5'd7, 32'h11);
`endif
    check("llu1_drained", debugCount, 2'd0);

    // starvation: two LLU results behind continuous writeback to x9
    drive_wb(1'b1, 5'd9, 32'h99);
    drive_llu(1'b1, 5'd3, 32'hA);
    tick();
    check_write("st_e1", 5'd9, 32'h99);
    check("st_e1_count", debugCount, 2'd1);
    drive_llu(1'b1, 5'd4, 32'hB);
    tick();
    check("st_e2_count", debugCount, 2'd2);
    check("st_full_ready", lluReady, 1'b0);
    drive_llu(1'b0, 5'd0, 32'd0);
    tick();
    check("st_e3_stall", pipeStall, 1'b0);
    tick();
    check("st_e4_stall", pipeStall, 1'b0);
    tick();
    check("st_e5_stall", pipeStall, 1'b1);
    check_write("st_e5", 5'd9, 32'h99);
    tick();
    check_write("st_pop3", 5'd3, 32'hA);
    check("st_pop3_stall", pipeStall, 1'b1);
    tick();
    check_write("st_pop4", 5'd4, 32'hB);
    check("st_release", pipeStall, 1'b0);
    check("st_count0", debugCount, 2'd0);
    tick();
    check_write("st_wb_resume", 5'd9, 32'h99);

    // x0 handling: writeback to x0 alongside a queued x6 result
    drive_wb(1'b1, 5'd0, 32'hBAD);
    drive_llu(1'b1, 5'd6, 32'h66);
    tick();
    drive_llu(1'b0, 5'd0, 32'd0);
`ifdef REGFILE_ARB_BYPASS_EN
    check_write("x6_byp", 5'd6, 32'h66);
    tick();
    check("x6_after_en", destinationEnable, 1'b0);
`else
    check("x6_t1_en", destinationEnable, 1'b0);
    check("x6_t1_count", debugCount, 2'd1);
    tick();
    check_write("x6_t2", 5'd6, 32'h66);
`endif
    drive_wb(1'b0, 5'd0, 32'd0);
    drive_llu(1'b1, 5'd0, 32'h77);
    check("llu_x0_ready", lluReady, 1'b1);
    tick();
    drive_llu(1'b0, 5'd0, 32'd0);
    check("llu_x0_count", debugCount, 2'd0);
    check("llu_x0_en", destinationEnable, 1'b0);

    // flush with two entries queued and an LLU offer in the flush cycle
    drive_wb(1'b1, 5'd9, 32'h98);
    drive_llu(1'b1, 5'd10, 32'h10);
    tick();
    drive_llu(1'b1, 5'd11, 32'h11);
    tick();
    check("fl_count2", debugCount, 2'd2);
    flush = 1'b1;
    drive_llu(1'b1, 5'd12, 32'h12);
    check("fl_ready", lluReady, 1'b0);
    tick();
    flush = 1'b0;
    drive_wb(1'b0, 5'd0, 32'd0);
    drive_llu(1'b0, 5'd0, 32'd0);
    check_write("fl_wb_completes", 5'd9, 32'h98);
    check("fl_count0", debugCount, 2'd0);
    check("fl_state", debugState, 1'b0);
    tick();
    check("fl_no_llu1", destinationEnable, 1'b0);
    tick();
    check("fl_no_llu2", destinationEnable, 1'b0);

    // push+pop during STALL, pointer wrap, order across 6 transfers
    drive_wb(1'b1, 5'd9, 32'h97);
    drive_llu(1'b1, 5'd21, 32'h2100_0001);
    exp_q.push_back({5'd21, 32'h2100_0001});
    tick();
    drive_llu(1'b1, 5'd22, 32'h2200_0002);
    exp_q.push_back({5'd22, 32'h2200_0002});
    tick();
    drive_llu(1'b1, 5'd23, 32'h2300_0003);
    exp_q.push_back({5'd23, 32'h2300_0003});
    tick();
    tick();
    tick();
    check("wr_stall", pipeStall, 1'b1);
    check("wr_count2", debugCount, 2'd2);
    tick();
    check_sb_write("wr_t1");
    check("wr_t1_count", debugCount, 2'd1);
    tick();
    check_sb_write("wr_t2");
    drive_llu(1'b1, 5'd24, 32'h2400_0004);
    exp_q.push_back({5'd24, 32'h2400_0004});
    tick();
    check_sb_write("wr_t3");
    check("wr_t3_count", debugCount, 2'd1);
    drive_llu(1'b1, 5'd25, 32'h2500_0005);
    exp_q.push_back({5'd25, 32'h2500_0005});
    tick();
    check_sb_write("wr_t4");
    drive_llu(1'b1, 5'd26, 32'h2600_0006);
    exp_q.push_back({5'd26, 32'h2600_0006});
    tick();
    check_sb_write("wr_t5");
    check("wr_t5_stall", pipeStall, 1'b1);
    drive_llu(1'b0, 5'd0, 32'd0);
    tick();
    check_sb_write("wr_t6");
    check("wr_release", pipeStall, 1'b0);
    check("wr_count0", debugCount, 2'd0);
    check("wr_sb_empty", exp_q.size(), 0);
    tick();
    check_write("wr_wb_resume", 5'd9, 32'h97);
    drive_wb(1'b0, 5'd0, 32'd0);
    tick();
    mon_on = 1'b0;

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
